// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch/decode boundary: opcodes, fixed
// instruction words and the IF/ID controller state encoding.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/if_id_hazard_ctrl_src_usage_decode.sv
// Maps an RV32 opcode to which register source fields the instruction reads.
module src_usage_decode
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  // Opcode to source-field usage; unknown opcodes never create a hazard.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
      end
      OP_BRANCH, OP_STORE, OP_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with load-use stall, EX redirect and EBREAK halt
// control, plus saturating stall/flush counters.
module if_id_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit EBREAK_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  output logic [31:0]      pc_plus_imm,
  output logic             pcSrc,
  output logic             pcWrite,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_r;
  logic [31:0]      id_pc_r;
  logic [31:0]      id_instr_r;
  logic             id_valid_r;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;

  logic uses_rs1_s;
  logic uses_rs2_s;
  logic hazard_s;
  logic is_ebreak_s;
  logic do_redirect_s;
  logic do_stall_s;
  logic do_halt_s;
  logic pc_write_s;
  logic pc_src_s;
  logic ex_bubble_s;
  logic [31:0] pc_plus_imm_s;

  src_usage_decode u_src_usage_decode (
    .opcode   (id_instr_r[6:0]),
    .uses_rs1 (uses_rs1_s),
    .uses_rs2 (uses_rs2_s)
  );

  assign hazard_s = id_valid_r & ex_mem_read & (ex_rd != 5'd0) &
                    ((uses_rs1_s & (id_instr_r[19:15] == ex_rd)) |
                     (uses_rs2_s & (id_instr_r[24:20] == ex_rd)));
  assign is_ebreak_s = EBREAK_HALT & id_valid_r & (id_instr_r == EBREAK_INSTR);

  // Prioritised fetch control; reset forces free-running fetch with no bubble.
  always_comb begin
    do_redirect_s = 1'b0;
    do_stall_s    = 1'b0;
    do_halt_s     = 1'b0;
    pc_write_s    = 1'b1;
    pc_src_s      = 1'b0;
    ex_bubble_s   = 1'b0;
    pc_plus_imm_s = 32'h0000_0000;
    if (reset) begin
      pc_write_s = 1'b1;
    end else if (state_r == HALTED) begin
      pc_write_s  = 1'b0;
      ex_bubble_s = 1'b1;
    end else if (ex_branch_taken) begin
      do_redirect_s = 1'b1;
      pc_src_s      = 1'b1;
      ex_bubble_s   = 1'b1;
      pc_plus_imm_s = ex_branch_target & 32'hFFFF_FFFE;
    end else if (hazard_s) begin
      do_stall_s  = 1'b1;
      pc_write_s  = 1'b0;
      ex_bubble_s = 1'b1;
    end else if (is_ebreak_s) begin
      do_halt_s   = 1'b1;
      pc_write_s  = 1'b0;
      ex_bubble_s = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  // IF/ID register, run/halt state and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= RUN;
      id_pc_r       <= 32'h0000_0000;
      id_instr_r    <= NOP_INSTR;
      id_valid_r    <= 1'b0;
      stall_count_r <= {CNT_W{1'b0}};
      flush_count_r <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      if (do_redirect_s) begin
        id_valid_r <= 1'b0;
        id_instr_r <= NOP_INSTR;
        if (flush_count_r != CNT_MAX) begin
          flush_count_r <= flush_count_r + CNT_ONE;
        end
      end else if (do_stall_s) begin
        if (stall_count_r != CNT_MAX) begin
          stall_count_r <= stall_count_r + CNT_ONE;
        end
      end else if (do_halt_s) begin
        state_r <= HALTED;
      end else begin
        id_pc_r    <= if_pc;
        id_instr_r <= if_instr;
        id_valid_r <= 1'b1;
      end
    end
  end

  assign pc_plus_imm = pc_plus_imm_s;
  assign pcSrc       = pc_src_s;
  assign pcWrite     = pc_write_s;
  assign ex_bubble   = ex_bubble_s;
  assign id_pc       = id_pc_r;
  assign id_instr    = id_instr_r;
  assign id_valid    = id_valid_r;
  assign halted      = (state_r == HALTED);
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench: two instances (16-bit and 4-bit counters) share one stimulus.
module tb_if_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_instr, ex_branch_target;
  logic        ex_branch_taken, ex_mem_read;
  logic [4:0]  ex_rd;

  logic [31:0] pc_plus_imm, id_pc, id_instr;
  logic        pcSrc, pcWrite, id_valid, ex_bubble, halted;
  logic [15:0] stall_count, flush_count;

  logic [31:0] pc_plus_imm_b, id_pc_b, id_instr_b;
  logic        pcSrc_b, pcWrite_b, id_valid_b, ex_bubble_b, halted_b;
  logic [3:0]  stall_count_b, flush_count_b;

  int vecs = 0;
  int errs = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI2  = 32'h0020_0113; // addi x2,x0,2
  localparam logic [31:0] ADD3   = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] LUI5   = 32'h0000_02B7; // lui x5,0
  localparam logic [31:0] ADDI7  = 32'h0050_0393; // addi x7,x0,5
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_plus_imm(pc_plus_imm),
    .pcSrc(pcSrc), .pcWrite(pcWrite), .id_pc(id_pc), .id_instr(id_instr),
    .id_valid(id_valid), .ex_bubble(ex_bubble), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_plus_imm(pc_plus_imm_b),
    .pcSrc(pcSrc_b), .pcWrite(pcWrite_b), .id_pc(id_pc_b), .id_instr(id_instr_b),
    .id_valid(id_valid_b), .ex_bubble(ex_bubble_b), .halted(halted_b),
    .stall_count(stall_count_b), .flush_count(flush_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h0; if_instr = NOP;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h105;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #2;
    check("rst_pcWrite", {31'd0, pcWrite}, 32'd1);
    check("rst_pcSrc", {31'd0, pcSrc}, 32'd0);
    check("rst_pc_plus_imm", pc_plus_imm, 32'd0);
    check("rst_ex_bubble", {31'd0, ex_bubble}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stall_count", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0; ex_branch_taken = 1'b0;

    // Straight-line fetch
    if_pc = 32'h0; if_instr = ADDI1; #1;
    check("c0_id_valid", {31'd0, id_valid}, 32'd0);
    check("c0_pcWrite", {31'd0, pcWrite}, 32'd1);
    tick();
    check("c1_id_pc", id_pc, 32'h0);
    check("c1_id_valid", {31'd0, id_valid}, 32'd1);
    check("c1_id_instr", id_instr, ADDI1);
    if_pc = 32'h4; if_instr = ADDI2; #1;
    check("c1_pcWrite", {31'd0, pcWrite}, 32'd1);
    tick();
    check("c2_id_pc", id_pc, 32'h4);
    if_pc = 32'h8; if_instr = ADD3;
    tick();
    check("c3_id_instr", id_instr, ADD3);

    // Load-use on rs2 of ADD: one-cycle stall
    ex_mem_read = 1'b1; ex_rd = 5'd2; if_pc = 32'hC; if_instr = NOP; #1;
    check("lu_pcWrite", {31'd0, pcWrite}, 32'd0);
    check("lu_ex_bubble", {31'd0, ex_bubble}, 32'd1);
    tick();
    check("lu_id_pc_hold", id_pc, 32'h8);
    check("lu_stall_count", {16'd0, stall_count}, 32'd1);
    ex_mem_read = 1'b0; #1;
    check("lu_release_pcWrite", {31'd0, pcWrite}, 32'd1);
    check("lu_release_bubble", {31'd0, ex_bubble}, 32'd0);
    tick();
    check("lu_advance_id_pc", id_pc, 32'hC);

    // LUI has no sources; x0 never stalls
    if_pc = 32'h10; if_instr = LUI5;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd5; if_pc = 32'h14; if_instr = ADDI7; #1;
    check("lui_no_stall", {31'd0, pcWrite}, 32'd1);
    tick();
    check("lui_id_instr", id_instr, ADDI7);
    ex_rd = 5'd0; if_pc = 32'h18; if_instr = NOP; #1;
    check("x0_no_stall", {31'd0, pcWrite}, 32'd1);
    check("x0_no_bubble", {31'd0, ex_bubble}, 32'd0);
    tick();
    check("x0_stall_count", {16'd0, stall_count}, 32'd1);

    // Redirect to an odd target
    ex_mem_read = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'h105;
    if_pc = 32'h1C; if_instr = ADDI1; #1;
    check("br_pcSrc", {31'd0, pcSrc}, 32'd1);
    check("br_pc_plus_imm", pc_plus_imm, 32'h104);
    check("br_ex_bubble", {31'd0, ex_bubble}, 32'd1);
    check("br_pcWrite", {31'd0, pcWrite}, 32'd1);
    tick();
    check("br_id_valid", {31'd0, id_valid}, 32'd0);
    check("br_id_instr", id_instr, NOP);
    check("br_flush_count", {16'd0, flush_count}, 32'd1);
    ex_branch_taken = 1'b0; if_pc = 32'h104; if_instr = ADD3;
    tick();
    check("br_target_id_pc", id_pc, 32'h104);
    check("br_target_valid", {31'd0, id_valid}, 32'd1);

    // Redirect and hazard together: redirect wins
    ex_mem_read = 1'b1; ex_rd = 5'd1; ex_branch_taken = 1'b1; ex_branch_target = 32'h200; #1;
    check("brhz_pcSrc", {31'd0, pcSrc}, 32'd1);
    check("brhz_pcWrite", {31'd0, pcWrite}, 32'd1);
    tick();
    check("brhz_stall_count", {16'd0, stall_count}, 32'd1);
    check("brhz_flush_count", {16'd0, flush_count}, 32'd2);
    check("brhz_id_valid", {31'd0, id_valid}, 32'd0);

    // Saturation: 20 consecutive load-use stalls
    ex_branch_taken = 1'b0; ex_mem_read = 1'b0; if_pc = 32'h200; if_instr = ADD3;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd2; if_pc = 32'h204; if_instr = EBRK;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("sat_pcWrite", {31'd0, pcWrite}, 32'd0);
      tick();
    end
    check("sat_stall16", {16'd0, stall_count}, 32'd21);
    check("sat_stall4", {28'd0, stall_count_b}, 32'd15);
    check("sat_id_pc_hold", id_pc, 32'h200);

    // EBREAK halt
    ex_mem_read = 1'b0;
    tick();
    check("eb_id_instr", id_instr, EBRK);
    #1;
    check("eb_pcWrite", {31'd0, pcWrite}, 32'd0);
    check("eb_ex_bubble", {31'd0, ex_bubble}, 32'd1);
    check("eb_not_yet_halted", {31'd0, halted}, 32'd0);
    if_pc = 32'h208; if_instr = NOP;
    tick();
    check("eb_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      ex_branch_taken = i[0]; ex_branch_target = 32'h300; #1;
      check("hlt_pcWrite", {31'd0, pcWrite}, 32'd0);
      check("hlt_pcSrc", {31'd0, pcSrc}, 32'd0);
      check("hlt_bubble", {31'd0, ex_bubble}, 32'd1);
      tick();
      check("hlt_id_pc", id_pc, 32'h204);
      check("hlt_flush", {16'd0, flush_count}, 32'd2);
    end
    check("hlt_stall4", {28'd0, stall_count_b}, 32'd15);

    // Asynchronous reset out of halt
    ex_branch_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    check("rst2_halted", {31'd0, halted}, 32'd0);
    check("rst2_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst2_stall", {16'd0, stall_count}, 32'd0);
    check("rst2_pcWrite", {31'd0, pcWrite}, 32'd1);
    tick();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Consumer and controller at the downstream end of the instruction-fetch interface.
- Captures the fetched {pc, instruction} pair into the IF/ID pipeline register and drives the fetch stage's pcWrite, pcSrc and pc_plus_imm.
- Resolves three conditions: load-use stalls, taken-branch/jump redirects from EX, and an EBREAK halt.
- Sits between the fetch stage and decode; feeds ID/EX bubble control.

Parameters:
- CNT_W, 16, width of the saturating stall and flush performance counters.
- EBREAK_HALT, 1, when 1 an EBREAK reaching ID halts fetch; when 0 EBREAK is passed through as a normal instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  32  PC currently presented by the fetch stage.
- if_instr  in  32  instruction at if_pc; combinational read, valid in the same cycle.
- ex_branch_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- ex_branch_target  in  32  redirect target; bit 0 is ignored and forced to 0.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- pc_plus_imm  out  32  redirect target to fetch.
- pcSrc  out  1  1 selects pc_plus_imm; 0 selects pc+4.
- pcWrite  out  1  PC update enable.
- id_pc  out  32  IF/ID register: PC.
- id_instr  out  32  IF/ID register: instruction.
- id_valid  out  1  IF/ID register holds a real instruction.
- ex_bubble  out  1  ID/EX must load a NOP this cycle.
- halted  out  1  core is halted.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (async): state=RUN; id_pc=0; id_instr=0x00000013 (NOP); id_valid=0; both counters=0; halted=0.
- Combinational outputs during reset: pcWrite=1, pcSrc=0, pc_plus_imm=0, ex_bubble=0.
- Source usage is decoded from id_instr[6:0]:
  - LUI, AUIPC, JAL: no sources.
  - JALR, LOAD, OP-IMM: rs1 only.
  - BRANCH, STORE, OP: rs1 and rs2.
  - Any other opcode: no sources.
- hazard = id_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- State RUN, priority order (first match wins):
  1. Redirect (ex_branch_taken=1):
     - Outputs this cycle: pcSrc=1, pc_plus_imm={target[31:1],0}, pcWrite=1, ex_bubble=1.
     - At the edge: id_valid<=0, id_instr<=NOP, flush_count++.
     - Two wrong-path instructions are squashed (the one in ID and the one in IF).
     - Overrides any hazard in the same cycle.
  2. Hazard:
     - Outputs this cycle: pcWrite=0, pcSrc=0, ex_bubble=1.
     - IF/ID holds its contents; stall_count++.
     - Stall lasts exactly one cycle, because the load leaves EX.
  3. EBREAK (EBREAK_HALT=1, id_valid=1, id_instr==0x00100073):
     - Outputs this cycle: pcWrite=0, ex_bubble=1.
     - At the edge: state<=HALTED, IF/ID holds.
  4. Otherwise:
     - Outputs this cycle: pcWrite=1, pcSrc=0, ex_bubble=0.
     - At the edge: IF/ID<={if_pc, if_instr}, id_valid<=1.
- State HALTED:
  - Outputs: pcWrite=0, ex_bubble=1, halted=1; IF/ID frozen; counters frozen.
  - ex_branch_taken is ignored, because EX only drains bubbles.
  - Exit only via reset.
- Counters saturate at all-ones and never wrap.
- Latency: fetch to id_* is one cycle. Redirect to first target instruction in ID is two cycles after the redirect cycle.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; no partial update.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP);
  - NOP_INSTR = 32'h00000013 and EBREAK_INSTR = 32'h00100073;
  - state enum ctrl_state_t {RUN, HALTED}.
- One natural sub-module: src_usage_decode (combinational; opcode -> uses_rs1, uses_rs2).
- The pipeline register, FSM and counters stay in the top module.

Test Plan:
- Reset then feed if_pc=0x0,0x4,0x8 with ADDI words -> id_valid=0 in cycle 0; id_pc=0x0 after 1st edge, 0x4 after 2nd; pcWrite=1 throughout.
- id_instr=ADD x3,x1,x2 with ex_mem_read=1, ex_rd=2 -> pcWrite=0, ex_bubble=1 for exactly one cycle; id_pc unchanged; stall_count=1.
- Load-use case: id_instr=LUI x5 with ex_rd=5, ex_mem_read=1 -> no stall (no sources). Zero-register case: ex_rd=0 with a matching rs1 -> no stall.
- ex_branch_taken=1, target=0x105 -> pcSrc=1, pc_plus_imm=0x104, ex_bubble=1; id_valid=0 next cycle; flush_count=1. Redirect together with a hazard in the same cycle -> redirect wins, stall_count unchanged.
- EBREAK reaches ID -> halted=1 from the next cycle; pcWrite stays 0 for 10+ cycles despite ex_branch_taken pulses. Asserting reset -> halted=0 and id_valid=0 immediately.
- CNT_W=4, force 20 consecutive load-use stalls -> stall_count saturates at 15 and does not wrap.
